// File: rtl/text_console_writer.sv
// Writes a 7-bit ASCII byte stream into character RAM port A at a tracked cursor.
// Optional macro CONSOLE_LINE_CLEAR_EN: blank the destination row on every new-row event.
//
// state        | meaning
// IDLE         | charReady high, one character accepted per cycle
// CLEAR_LINE   | writing 0x20 across the cursor row, one address per cycle
// CLEAR_SCREEN | writing 0x20 to every cell, one address per cycle
module text_console_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 60
) (
  input  logic        clock50MHz,
  input  logic        resetn,
  input  logic        charValid,
  input  logic [6:0]  charIn,
  output logic        charReady,
  output logic        charRamWrEn,
  output logic [12:0] charRamAddr,
  output logic [6:0]  charRamData,
  output logic [6:0]  cursorCol,
  output logic [5:0]  cursorRow
);

  typedef enum logic [1:0] {IDLE, CLEAR_LINE, CLEAR_SCREEN} state_t;

  localparam logic [12:0] COLS_W    = 13'(COLS);
  localparam logic [12:0] LAST_CELL = 13'(COLS * ROWS - 1);
  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [5:0]  LAST_ROW  = 6'(ROWS - 1);
  localparam logic [6:0]  BLANK     = 7'h20;

  state_t      state, state_nx;
  logic [12:0] clr_addr, clr_addr_nx;
  logic [12:0] clr_last, clr_last_nx;
  logic        wr_en_nx;
  logic [12:0] addr_nx;
  logic [6:0]  data_nx;
  logic [6:0]  col_nx;
  logic [5:0]  row_nx;

  logic        accept;
  logic        is_print, is_lf, is_cr, is_bs, is_ff;
  logic        new_row;
  logic        clr_done;
  logic [12:0] cur_addr;
  logic [5:0]  row_inc;

  assign charReady = (state == IDLE);
  assign accept    = charValid && (state == IDLE);
  assign is_print  = (charIn >= 7'h20) && (charIn <= 7'h7E);
  assign is_lf     = (charIn == 7'h0A);
  assign is_cr     = (charIn == 7'h0D);
  assign is_bs     = (charIn == 7'h08);
  assign is_ff     = (charIn == 7'h0C);
  assign new_row   = accept && ((is_print && cursorCol == LAST_COL) || is_lf);
  assign clr_done  = (clr_addr == clr_last);
  assign cur_addr  = {7'd0, cursorRow} * COLS_W + {6'd0, cursorCol};
  assign row_inc   = (cursorRow == LAST_ROW) ? 6'd0 : cursorRow + 6'd1;

`ifdef CONSOLE_LINE_CLEAR_EN
  logic [12:0] row_base;
  assign row_base = {7'd0, row_inc} * COLS_W;
`endif

  always_ff @(posedge clock50MHz) begin
    if (!resetn) begin
      state       <= CLEAR_SCREEN;
      clr_addr    <= '0;
      clr_last    <= LAST_CELL;
      charRamWrEn <= 1'b0;
      charRamAddr <= '0;
      charRamData <= '0;
      cursorCol   <= '0;
      cursorRow   <= '0;
    end else begin
      state       <= state_nx;
      clr_addr    <= clr_addr_nx;
      clr_last    <= clr_last_nx;
      charRamWrEn <= wr_en_nx;
      charRamAddr <= addr_nx;
      charRamData <= data_nx;
      cursorCol   <= col_nx;
      cursorRow   <= row_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept && is_ff) begin
          state_nx = CLEAR_SCREEN;
        end
`ifdef CONSOLE_LINE_CLEAR_EN
        else if (new_row) begin
          state_nx = CLEAR_LINE;
        end
`endif
      end
      CLEAR_LINE, CLEAR_SCREEN: begin
        if (clr_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    wr_en_nx    = 1'b0;
    addr_nx     = charRamAddr;
    data_nx     = charRamData;
    col_nx      = cursorCol;
    row_nx      = cursorRow;
    clr_addr_nx = clr_addr;
    clr_last_nx = clr_last;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_print) begin
            wr_en_nx = 1'b1;
            addr_nx  = cur_addr;
            data_nx  = charIn;
            if (cursorCol != LAST_COL) col_nx = cursorCol + 7'd1;
          end else if (is_cr) begin
            col_nx = '0;
          end else if (is_bs && cursorCol != 7'd0) begin
            wr_en_nx = 1'b1;
            addr_nx  = cur_addr - 13'd1;
            data_nx  = BLANK;
            col_nx   = cursorCol - 7'd1;
          end else if (is_ff) begin
            col_nx      = '0;
            row_nx      = '0;
            clr_addr_nx = '0;
            clr_last_nx = LAST_CELL;
          end
          if (new_row) begin
            col_nx = '0;
            row_nx = row_inc;
`ifdef CONSOLE_LINE_CLEAR_EN
            clr_addr_nx = row_base;
            clr_last_nx = row_base + COLS_W - 13'd1;
`endif
          end
        end
      end
      CLEAR_LINE, CLEAR_SCREEN: begin
        wr_en_nx    = 1'b1;
        addr_nx     = clr_addr;
        data_nx     = BLANK;
        clr_addr_nx = clr_addr + 13'd1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: cycle-level reference model built on a pending-clear
// address range, directed literal checks, then randomized traffic with resets.
module tb_text_console_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 60;
  localparam int NCELL = COLS * ROWS;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        charValid = 1'b0;
  logic [6:0]  charIn = 7'h00;
  logic        charReady, charRamWrEn;
  logic [12:0] charRamAddr;
  logic [6:0]  charRamData, cursorCol;
  logic [5:0]  cursorRow;

  int checks = 0;
  int failures = 0;

  text_console_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clock50MHz (clk),
    .resetn     (resetn),
    .charValid  (charValid),
    .charIn     (charIn),
    .charReady  (charReady),
    .charRamWrEn(charRamWrEn),
    .charRamAddr(charRamAddr),
    .charRamData(charRamData),
    .cursorCol  (cursorCol),
    .cursorRow  (cursorRow)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cursor position plus a half-open range [p_lo,p_hi) of blanks still owed.
  int m_col, m_row, p_lo, p_hi;
  int e_wr, e_addr, e_data, e_ready;
  bit model_valid = 0;

  function automatic void model_new_row();
    m_col = 0;
    m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
`ifdef CONSOLE_LINE_CLEAR_EN
    p_lo = m_row * COLS;
    p_hi = p_lo + COLS;
`endif
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      m_col = 0; m_row = 0; p_lo = 0; p_hi = NCELL;
      e_wr = 0; e_addr = 0; e_data = 0;
    end else if (p_lo < p_hi) begin
      e_wr = 1; e_addr = p_lo; e_data = 32; p_lo++;
    end else begin
      e_wr = 0;
      if (charValid) begin
        if (charIn >= 7'h20 && charIn <= 7'h7E) begin
          e_wr = 1; e_addr = m_row * COLS + m_col; e_data = int'(charIn);
          if (m_col == COLS - 1) model_new_row();
          else m_col++;
        end else if (charIn == 7'h0A) begin
          model_new_row();
        end else if (charIn == 7'h0D) begin
          m_col = 0;
        end else if (charIn == 7'h08) begin
          if (m_col > 0) begin
            m_col--; e_wr = 1; e_addr = m_row * COLS + m_col; e_data = 32;
          end
        end else if (charIn == 7'h0C) begin
          m_col = 0; m_row = 0; p_lo = 0; p_hi = NCELL;
        end
      end
    end
    e_ready = (p_lo >= p_hi) ? 1 : 0;
    model_valid = 1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("ready", charReady, e_ready);
      chk("wr_en", charRamWrEn, e_wr);
      chk("addr", charRamAddr, e_addr);
      chk("data", charRamData, e_data);
      chk("col", cursorCol, m_col);
      chk("row", cursorRow, m_row);
    end
  end

  task automatic send(input logic [6:0] c);
    int n = 0;
    while (!charReady && n < 10000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10000) chk("send_timeout", 1, 0);
    charValid = 1'b1;
    charIn    = c;
    @(negedge clk);
    charValid = 1'b0;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!charReady && cycles < 6000);
  endtask

  initial begin
    int n;
    int r;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", charReady, 0);
    chk("rst_wr", charRamWrEn, 0);
    chk("rst_addr", charRamAddr, 0);
    chk("rst_data", charRamData, 0);

    resetn = 1'b1;
    wait_ready(n);
    chk("reset_clear_len", n, 4800);
    chk("reset_clear_last", charRamAddr, 4799);
    chk("reset_cursor", {cursorRow, cursorCol}, 0);

    send(7'h41);
    chk("A_addr", charRamAddr, 0);
    chk("A_data", charRamData, 7'h41);
    send(7'h42);
    chk("B_addr", charRamAddr, 1);
    chk("B_data", charRamData, 7'h42);
    chk("B_col", cursorCol, 2);

    send(7'h0D);
    for (int i = 0; i < 80; i++) send(7'h78);
    send(7'h5A);
    chk("wrap_addr", charRamAddr, 80);
    chk("wrap_data", charRamData, 7'h5A);
    chk("wrap_cursor", {cursorRow, cursorCol}, {6'd1, 7'd1});

    send(7'h0D);
    send(7'h0A);
    send(7'h61); send(7'h62); send(7'h63);
    send(7'h08);
    chk("bs_wr", charRamWrEn, 1);
    chk("bs_addr", charRamAddr, 162);
    chk("bs_data", charRamData, 7'h20);
    chk("bs_cursor", {cursorRow, cursorCol}, {6'd2, 7'd2});
    send(7'h0D);
    send(7'h08);
    chk("bs0_wr", charRamWrEn, 0);
    chk("bs0_cursor", {cursorRow, cursorCol}, {6'd2, 7'd0});
    send(7'h07);
    chk("bel_wr", charRamWrEn, 0);

    for (int i = 0; i < 57; i++) send(7'h0A);
    for (int i = 0; i < 10; i++) send(7'h71);
    chk("pre_lf_cursor", {cursorRow, cursorCol}, {6'd59, 7'd10});
    send(7'h0A);
    chk("lf_wrap_cursor", {cursorRow, cursorCol}, 0);

    for (int i = 0; i < 5; i++) send(7'h0A);
    for (int i = 0; i < 5; i++) send(7'h66);
    send(7'h0C);
    chk("ff_ready", charReady, 0);
    chk("ff_cursor", {cursorRow, cursorCol}, 0);
    n = 0;
    while (!(charRamWrEn && charRamAddr == 13'd1000) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("ff_reach_1000", n, 1001);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    wait_ready(n);
    chk("rerun_clear_len", n, 4800);

    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      charValid = ($urandom_range(0, 3) != 0);
      if (r < 2) charIn = 7'h0C;
      else if (r < 60) charIn = 7'h0A;
      else if (r < 100) charIn = 7'h0D;
      else if (r < 160) charIn = 7'h08;
      else if (r < 200) charIn = 7'($urandom_range(0, 31));
      else if (r < 210) charIn = 7'h7F;
      else charIn = 7'($urandom_range(32, 126));
      resetn = ($urandom_range(0, 1499) != 0);
      @(negedge clk);
    end
    charValid = 1'b0;
    resetn = 1'b1;
    wait_ready(n);
    chk("final_ready", charReady, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
